// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential word
// requests to the icache, buffers {pc, instr} pairs in a small FIFO with a
// registered head toward decode, and restarts fetch on redirect.
module ifetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_req,
  input  logic [DATA_WIDTH-1:0] ic_rdata,
  input  logic                  ic_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  out_ready
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_nxt;
  logic                    req_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [ADDR_WIDTH-1:0]   target;
  logic [ADDR_WIDTH-1:0]   pc_plus4;

  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0]        wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]        count, count_nxt;
  logic                    push, pop, flush;
  logic [ENTRY_W-1:0]      push_entry;

  logic                    out_valid_nxt;
  logic [DATA_WIDTH-1:0]   out_instr_nxt;
  logic [ADDR_WIDTH-1:0]   out_pc_nxt;

  assign target     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign pc_plus4   = fetch_pc + ADDR_WIDTH'(3'd4);
  assign push_entry = {fetch_pc, ic_rdata};

  // FIFO bookkeeping: redirect flushes and overrides any push/pop this cycle.
  always_comb begin
    flush      = redirect_valid;
    push       = (state == RUN) && !redirect_valid && ic_req && ic_ready;
    pop        = out_valid && out_ready && !redirect_valid;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (flush) begin
      rd_ptr_nxt = {PTR_W{1'b0}};
      wr_ptr_nxt = {PTR_W{1'b0}};
      count_nxt  = {CNT_W{1'b0}};
    end else begin
      rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1'b1) : rd_ptr;
      wr_ptr_nxt = push ? wr_ptr + PTR_W'(1'b1) : wr_ptr;
      count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Next registered head: bypass the pushed entry when the FIFO would
  // otherwise be empty, so out_valid follows ic_ready by exactly one cycle.
  always_comb begin
    out_valid_nxt = (count_nxt != {CNT_W{1'b0}});
    out_instr_nxt = out_instr;
    out_pc_nxt    = out_pc;
    if (flush || (count_nxt == {CNT_W{1'b0}})) begin
      out_instr_nxt = out_instr;
      out_pc_nxt    = out_pc;
    end else if (count == CNT_W'(pop)) begin
      out_pc_nxt    = push_entry[ENTRY_W-1:DATA_WIDTH];
      out_instr_nxt = push_entry[DATA_WIDTH-1:0];
    end else begin
      out_pc_nxt    = mem[rd_ptr_nxt][ENTRY_W-1:DATA_WIDTH];
      out_instr_nxt = mem[rd_ptr_nxt][DATA_WIDTH-1:0];
    end
  end

  // Fetch control: request issue/hold, PC advance, redirect and drain.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = ic_req;
    addr_nxt     = ic_addr;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          fetch_pc_nxt = target;
          if (ic_req && !ic_ready) begin
            // Stale request must complete; keep it stable and absorb it later.
            state_nxt = DRAIN;
          end else begin
            req_nxt  = 1'b1;
            addr_nxt = target;
          end
        end else if (ic_req && ic_ready) begin
          fetch_pc_nxt = pc_plus4;
          req_nxt      = (count_nxt < CNT_W'(DEPTH));
          addr_nxt     = pc_plus4;
        end else if (!ic_req) begin
          req_nxt  = (count_nxt < CNT_W'(DEPTH));
          addr_nxt = fetch_pc;
        end else begin
          // Outstanding request: hold ic_req/ic_addr until the response.
          req_nxt  = 1'b1;
          addr_nxt = ic_addr;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          fetch_pc_nxt = target;
        end else begin
          fetch_pc_nxt = fetch_pc;
        end
        if (ic_ready) begin
          state_nxt = RUN;
          req_nxt   = 1'b1;
          addr_nxt  = redirect_valid ? target : fetch_pc;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Control and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      ic_req    <= 1'b0;
      ic_addr   <= RESET_PC;
      rd_ptr    <= {PTR_W{1'b0}};
      wr_ptr    <= {PTR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
      out_instr <= {DATA_WIDTH{1'b0}};
      out_pc    <= {ADDR_WIDTH{1'b0}};
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      ic_req    <= req_nxt;
      ic_addr   <= addr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      out_instr <= out_instr_nxt;
      out_pc    <= out_pc_nxt;
    end
  end

  // FIFO storage write; contents are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  ifetch_queue_checker #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .count (count)
  );

endmodule

// Protocol checker: a push must never land in a full FIFO.
module ifetch_queue_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic [CNT_W-1:0] count
);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) push |-> (count < CNT_W'(DEPTH))
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized
// traffic, all checked each cycle against a queue-based behavioural model.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic [31:0] ic_rdata = 32'h0;
  logic        ic_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  ifetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_addr        (ic_addr),
    .ic_req         (ic_req),
    .ic_rdata       (ic_rdata),
    .ic_ready       (ic_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the outputs must look like after the next edge.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_drain;
  int          age;
  logic [31:0] pop_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ic_req", {31'b0, ic_req}, {31'b0, m_req});
      if (m_req) chk("ic_addr", ic_addr, m_addr);
      chk("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
      if (m_q.size() > 0) begin
        chk("out_pc", out_pc, m_q[0].pc);
        chk("out_instr", out_instr, m_q[0].instr);
      end
    end
  end

  task automatic model_reset();
    m_q.delete();
    m_pc    = RPC;
    m_req   = 1'b0;
    m_addr  = RPC;
    m_drain = 1'b0;
    age     = 0;
  endtask

  function automatic logic rdy_for(input int delay);
    return m_req && (age >= delay);
  endfunction

  // Drive one cycle of inputs, advance the model, and move to the next
  // sampling point (just after the falling edge).
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic ordy);
    logic [31:0] rd;
    logic [31:0] tgt;
    logic        prior_req;
    rd  = $urandom;
    tgt = {rpc[31:2], 2'b00};
    if (ordy && out_valid && !redir) pop_log.push_back(out_pc);
    redirect_valid = redir;
    redirect_pc    = rpc;
    ic_ready       = rdy;
    ic_rdata       = rd;
    out_ready      = ordy;
    prior_req      = m_req;
    if (m_drain) begin
      if (redir) m_pc = tgt;
      if (rdy) begin
        m_drain = 1'b0;
        m_req   = 1'b1;
        m_addr  = m_pc;
      end
    end else if (redir) begin
      m_q.delete();
      m_pc = tgt;
      if (m_req && !rdy) begin
        m_drain = 1'b1;
      end else begin
        m_req  = 1'b1;
        m_addr = tgt;
      end
    end else begin
      if (ordy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_req && rdy) begin
        m_q.push_back('{pc: m_addr, instr: rd});
        m_pc   = m_addr + 32'd4;
        m_addr = m_pc;
        m_req  = (m_q.size() < DEPTH);
      end else if (!m_req) begin
        m_req  = (m_q.size() < DEPTH);
        m_addr = m_pc;
      end
    end
    age = (prior_req && m_req && !rdy && !redir) ? age + 1 : 0;
    @(negedge clk);
    #1;
  endtask

  // Assert reset (optionally checking reset values immediately), then release.
  task automatic do_reset(input bit check_vals);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    ic_ready       = 1'b0;
    out_ready      = 1'b0;
    model_reset();
    #1;
    if (check_vals) begin
      chk("rst_ic_req", {31'b0, ic_req}, 32'd0);
      chk("rst_ic_addr", ic_addr, RPC);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    do_reset(1'b1);

    // 1: responses two cycles after each request, decode always ready.
    pop_log.delete();
    for (int i = 0; i < 80 && pop_log.size() < 4; i++) step(1'b0, 32'h0, rdy_for(2), 1'b1);
    chk("t1_pop_count", pop_log.size(), 32'd4);
    if (pop_log.size() >= 4) begin
      chk("t1_pc0", pop_log[0], 32'h100);
      chk("t1_pc1", pop_log[1], 32'h104);
      chk("t1_pc2", pop_log[2], 32'h108);
      chk("t1_pc3", pop_log[3], 32'h10C);
    end

    // 2: fill the FIFO with decode stalled, then free one slot.
    do_reset(1'b0);
    repeat (8) step(1'b0, 32'h0, rdy_for(0), 1'b0);
    chk("t2_model_count", m_q.size(), 32'd4);
    chk("t2_req_low", {31'b0, ic_req}, 32'd0);
    chk("t2_head_pc", out_pc, 32'h100);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t2_req_again", {31'b0, ic_req}, 32'd1);
    chk("t2_addr", ic_addr, 32'h110);

    // 3: redirect while a request is outstanding; stale data is absorbed.
    do_reset(1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h2002, 1'b0, 1'b0);
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_stale_addr", ic_addr, 32'h100);
    chk("t3_stale_req", {31'b0, ic_req}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t3_new_addr", ic_addr, 32'h2000);
    chk("t3_no_stale", {31'b0, out_valid}, 32'd0);
    pop_log.delete();
    for (int i = 0; i < 40 && pop_log.size() < 1; i++) step(1'b0, 32'h0, rdy_for(1), 1'b1);
    chk("t3_pop_count", {31'b0, (pop_log.size() >= 1)}, 32'd1);
    if (pop_log.size() >= 1) chk("t3_first_pc", pop_log[0], 32'h2000);

    // 4: redirect coincident with response and pop.
    do_reset(1'b0);
    for (int i = 0; i < 20 && !(out_valid && ic_req); i++) step(1'b0, 32'h0, rdy_for(0), 1'b1);
    chk("t4_pre", {31'b0, (out_valid && ic_req)}, 32'd1);
    step(1'b1, 32'h3000, 1'b1, 1'b1);
    chk("t4_flushed", {31'b0, out_valid}, 32'd0);
    chk("t4_req", {31'b0, ic_req}, 32'd1);
    chk("t4_addr", ic_addr, 32'h3000);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_no_drain_valid", {31'b0, out_valid}, 32'd1);
    chk("t4_no_drain_pc", out_pc, 32'h3000);

    // 5: PC wrap, then reset in the middle of a request.
    do_reset(1'b0);
    repeat (3) step(1'b0, 32'h0, rdy_for(0), 1'b1);
    step(1'b1, 32'hFFFF_FFFC, rdy_for(0), 1'b1);
    pop_log.delete();
    for (int i = 0; i < 20 && pop_log.size() < 2; i++) step(1'b0, 32'h0, rdy_for(0), 1'b1);
    chk("t5_pop_count", {31'b0, (pop_log.size() >= 2)}, 32'd1);
    if (pop_log.size() >= 2) begin
      chk("t5_pc_top", pop_log[0], 32'hFFFF_FFFC);
      chk("t5_pc_wrap", pop_log[1], 32'h0000_0000);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset(1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_after_rst_req", {31'b0, ic_req}, 32'd1);
    chk("t5_after_rst_addr", ic_addr, RPC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic redir;
      redir = ($urandom_range(0, 19) == 0);
      step(redir, $urandom, m_req && ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
